minicpu_serpcu_seq: RTL and testbench
=====================================

MINICPU_SERPCU_SEQ -- requirements
Module: minicpu_serpcu_seq

Interface
REQ-001 The block SHALL provide parameter pWidth, default 16, which sets the width of the IP, W and Op registers (legal 8..32).
REQ-002 The block SHALL provide parameter pIP_Rst, default 0, which is the IP reset value.
REQ-003 The block SHALL provide parameter pW_Rst, default 0, which is the W reset value.
REQ-004 The block SHALL provide port Clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-005 The block SHALL provide port Rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL provide port Start, input, 1 bit: a request to begin the word operation given by Cmd.
REQ-007 The block SHALL provide port Cmd, input, 3 bits: word operation select (0 NOP, 1 IP_INC, 2 IP_ADD_OP, 3 W_ADD_OP, 4 IP_LD, 5 W_LD, 6 IP_OUT, 7 W_OUT).
REQ-008 The block SHALL provide port Op_En, input, 1 bit: shift one bit into Op this cycle.
REQ-009 The block SHALL provide port Op_Inv, input, 1 bit: complement Op on this shift (NFX last bit).
REQ-010 The block SHALL provide port PCU_DI, input, 1 bit: serial data in, used for Op shifts and LSB-first for IP_LD/W_LD.
REQ-011 The block SHALL provide port PCU_DO, output, 1 bit: serial data out.
REQ-012 The block SHALL provide port Busy, output, 1 bit: a word operation is in progress.
REQ-013 The block SHALL provide port Done, output, 1 bit: a one-cycle completion pulse.
REQ-014 The block SHALL provide port Cy, output, 1 bit: the registered carry-out of the last arithmetic operation.
REQ-015 The block SHALL provide port TstPort, output, 3*pWidth bits: {IP, W, Op} for debug.

Function
REQ-016 The block SHALL sample Start only when Busy=0; it SHALL ignore Start while Busy=1, and SHALL treat Cmd=0 with Start as a no-op (Busy stays 0).
REQ-017 The block SHALL latch Cmd at the accepting edge E0, set Busy=1 after E0, and process bit i (LSB first, i=0..pWidth-1) at edge E(i+1) using an internal bit counter.
REQ-018 After edge E(pWidth), the block SHALL clear Busy, pulse Done high for exactly one cycle, and accept a new Start in that Done cycle (back-to-back).
REQ-019 The block SHALL implement word operations by right-rotating the target register each bit cycle, with the result bit entering the MSB, so the target is complete after E(pWidth).
REQ-020 IP_INC SHALL serially add 0 with carry-in 1; IP_ADD_OP / W_ADD_OP SHALL serially add Op with carry-in 0; results SHALL be modulo 2^pWidth.
REQ-021 The ADD_OP commands SHALL rotate Op alongside the target and load Op=0 at E(pWidth).
REQ-022 IP_LD / W_LD SHALL shift PCU_DI in LSB first, so bit i of the new value is the PCU_DI sampled at E(i+1).
REQ-023 IP_OUT / W_OUT SHALL present the selected register's current LSB on PCU_DO each bit cycle, and SHALL leave the register unchanged after the full rotation.
REQ-024 PCU_DO SHALL carry the sum bit during arithmetic commands, the register LSB during OUT commands, and 0 when idle or during LD.
REQ-025 Cy SHALL update at E(pWidth) for arithmetic commands only, and SHALL hold otherwise.
REQ-026 On an Op_En edge, the block SHALL load Op={Op[pWidth-2:0],PCU_DI}, or the bitwise complement of that value when Op_Inv=1; Op_Inv without Op_En SHALL be ignored.
REQ-027 The block SHALL ignore Op_En while Busy with IP_ADD_OP or W_ADD_OP; during any other command or when idle, an Op shift SHALL proceed concurrently.

Reset
REQ-028 Rst=1 SHALL immediately set IP=pIP_Rst, W=pW_Rst, Op=0, Cy=0, Busy=0, Done=0, PCU_DO=0 and clear the bit counter, independent of Clk.
REQ-029 Rst asserted mid-operation SHALL abort the operation with no Done pulse; the first Start accepted after Rst falls SHALL begin a fresh operation from bit 0.

Verification
REQ-030 Reset (pWidth=16, defaults): TstPort=0, Busy=0, Done=0, PCU_DO=0, Cy=0.
REQ-031 Two IP_INC from reset: Busy high 16 cycles each, one Done each, IP=0x0002, Cy=0.
REQ-032 Op shifts (MSB-first nibbles) NFX F, then PFX 5, then NFX 0 (Op_Inv on the 4th bit of each NFX): Op=0xFFF0, then 0xFF05, then 0x0FAF.
REQ-033 With IP=0x0002 and Op=0x0FAF, IP_ADD_OP gives IP=0x0FB1, Op=0x0000, Cy=0; with IP=0xFFFF, IP_INC gives IP=0x0000, Cy=1.
REQ-034 W_LD with PCU_DI = 0x1234 LSB first gives W=0x1234; a following W_OUT gives PCU_DO bits 0,0,1,0,1,1,0,0,0,1,0,0,1,0,0,0 and W=0x1234.
REQ-035 Rst pulsed after bit 7 of IP_INC: IP=0, Busy=0, no Done; with pWidth=8, IP=0xFF then IP_INC gives IP=0x00, Busy high 8 cycles, Cy=1.

Source files
------------

// File: rtl/minicpu_serpcu_seq_if.sv
// Bus bundle for the serial program-counter unit: command handshake,
// Op shift controls, serial data in/out, status and the debug port.
interface minicpu_serpcu_seq_if #(
   parameter int pWidth = 16
);
   logic                  Start;
   logic [2:0]            Cmd;
   logic                  Op_En;
   logic                  Op_Inv;
   logic                  PCU_DI;
   logic                  PCU_DO;
   logic                  Busy;
   logic                  Done;
   logic                  Cy;
   logic [3*pWidth-1:0]   TstPort;

   modport master (
      output Start, Cmd, Op_En, Op_Inv, PCU_DI,
      input  PCU_DO, Busy, Done, Cy, TstPort
   );

   modport slave (
      input  Start, Cmd, Op_En, Op_Inv, PCU_DI,
      output PCU_DO, Busy, Done, Cy, TstPort
   );
endinterface

// File: rtl/minicpu_serpcu_seq.sv
// Bit-serial program-counter unit. Holds the instruction pointer (IP), a
// workspace pointer (W) and an operand register (Op). Word operations walk
// the target register one bit per clock, LSB first, by right-rotating it and
// feeding the result bit into the MSB, so a full word takes pWidth cycles.
module minicpu_serpcu_seq #(
   parameter int              pWidth  = 16,
   parameter logic [pWidth-1:0] pIP_Rst = '0,
   parameter logic [pWidth-1:0] pW_Rst  = '0
) (
   input  logic                 Clk,
   input  logic                 Rst,
   minicpu_serpcu_seq_if.slave  bus
);

   localparam int cCntW = $clog2(pWidth);
   localparam logic [cCntW-1:0] cLastBit = cCntW'(pWidth - 1);

   typedef enum logic [2:0] {
      cmdNop    = 3'd0,
      cmdIpInc  = 3'd1,
      cmdIpAdd  = 3'd2,
      cmdWAdd   = 3'd3,
      cmdIpLd   = 3'd4,
      cmdWLd    = 3'd5,
      cmdIpOut  = 3'd6,
      cmdWOut   = 3'd7
   } cmd_t;

   typedef enum logic {
      stIdle = 1'b0,
      stRun  = 1'b1
   } state_t;

   state_t              state_q, state_d;
   cmd_t                cmd_q, cmd_d;
   logic [cCntW-1:0]    cnt_q, cnt_d;
   logic                carry_q, carry_d;
   logic [pWidth-1:0]   ip_q, ip_d;
   logic [pWidth-1:0]   w_q, w_d;
   logic [pWidth-1:0]   op_q, op_d;
   logic                cy_q, cy_d;
   logic                done_q, done_d;
   logic                doBit;

   logic                ipTarget;
   logic                isArith;
   logic                isAddOp;
   logic [pWidth-1:0]   target;
   logic                addend;
   logic                sumBit;
   logic                carryOut;
   logic [pWidth-1:0]   newTarget;
   logic [pWidth-1:0]   shiftedOp;

   // State register; reset is asynchronous so an abort takes effect at once.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q <= stIdle;
         cmd_q   <= cmdNop;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         ip_q    <= pIP_Rst;
         w_q     <= pW_Rst;
         op_q    <= '0;
         cy_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         ip_q    <= ip_d;
         w_q     <= w_d;
         op_q    <= op_d;
         cy_q    <= cy_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic: command acceptance, one serial bit step per cycle while
   // running, and the Op shifter which runs alongside anything except ADD_OP.
   always_comb begin
      state_d   = state_q;
      cmd_d     = cmd_q;
      cnt_d     = cnt_q;
      carry_d   = carry_q;
      ip_d      = ip_q;
      w_d       = w_q;
      op_d      = op_q;
      cy_d      = cy_q;
      done_d    = 1'b0;
      doBit     = 1'b0;

      ipTarget  = (cmd_q == cmdIpInc) || (cmd_q == cmdIpAdd) ||
                  (cmd_q == cmdIpLd)  || (cmd_q == cmdIpOut);
      isAddOp   = (cmd_q == cmdIpAdd) || (cmd_q == cmdWAdd);
      isArith   = isAddOp || (cmd_q == cmdIpInc);
      target    = ipTarget ? ip_q : w_q;
      addend    = isAddOp ? op_q[0] : 1'b0;
      sumBit    = target[0] ^ addend ^ carry_q;
      carryOut  = (target[0] & addend) | (carry_q & (target[0] ^ addend));
      newTarget = {target[0], target[pWidth-1:1]};
      shiftedOp = {op_q[pWidth-2:0], bus.PCU_DI};

      if (bus.Op_En && !((state_q == stRun) && isAddOp)) begin
         op_d = bus.Op_Inv ? ~shiftedOp : shiftedOp;
      end

      case (state_q)
         stIdle: begin
            if (bus.Start && (bus.Cmd != 3'd0)) begin
               cmd_d   = cmd_t'(bus.Cmd);
               state_d = stRun;
               cnt_d   = '0;
               carry_d = (cmd_t'(bus.Cmd) == cmdIpInc);
            end
         end
         stRun: begin
            case (cmd_q)
               cmdIpInc, cmdIpAdd, cmdWAdd: begin
                  newTarget = {sumBit, target[pWidth-1:1]};
                  doBit     = sumBit;
               end
               cmdIpLd, cmdWLd: begin
                  newTarget = {bus.PCU_DI, target[pWidth-1:1]};
               end
               cmdIpOut, cmdWOut: begin
                  doBit     = target[0];
               end
               default: begin
                  newTarget = target;
               end
            endcase

            if (ipTarget) begin
               ip_d = newTarget;
            end else begin
               w_d = newTarget;
            end

            if (isAddOp) begin
               op_d = {op_q[0], op_q[pWidth-1:1]};
            end

            carry_d = carryOut;
            cnt_d   = cnt_q + cCntW'(1);

            if (cnt_q == cLastBit) begin
               state_d = stIdle;
               done_d  = 1'b1;
               cnt_d   = '0;
               if (isArith) begin
                  cy_d = carryOut;
               end
               if (isAddOp) begin
                  op_d = '0;
               end
            end
         end
         default: begin
            state_d = stIdle;
         end
      endcase
   end

   assign bus.PCU_DO  = doBit;
   assign bus.Busy    = (state_q == stRun);
   assign bus.Done    = done_q;
   assign bus.Cy      = cy_q;
   assign bus.TstPort = {ip_q, w_q, op_q};

endmodule

// File: tb/tb_minicpu_serpcu_seq.sv
// Directed bench for the serial PCU. Expected register contents are pushed
// onto a scoreboard when a command is issued and popped when Done arrives.
// A 16-bit and an 8-bit instance share one stimulus path selected by sel8.
module tb_minicpu_serpcu_seq;

   typedef struct {
      logic [31:0] ip;
      logic [31:0] w;
      logic [31:0] op;
      logic        cy;
      int          busy;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst16 = 1'b1;
   logic        rst8 = 1'b1;
   logic        sel8 = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  cmd = 3'd0;
   logic        opEn = 1'b0;
   logic        opInv = 1'b0;
   logic        di = 1'b0;
   bit          holdOpEn = 1'b0;
   bit          pokeWhileBusy = 1'b0;

   int          errCount = 0;
   int          checkCount = 0;

   exp_t        sbQ[$];
   logic        doQ[$];

   minicpu_serpcu_seq_if #(.pWidth(16)) bus16 ();
   minicpu_serpcu_seq_if #(.pWidth(8))  bus8 ();

   assign bus16.Start  = sel8 ? 1'b0 : start;
   assign bus16.Cmd    = sel8 ? 3'd0 : cmd;
   assign bus16.Op_En  = sel8 ? 1'b0 : opEn;
   assign bus16.Op_Inv = sel8 ? 1'b0 : opInv;
   assign bus16.PCU_DI = sel8 ? 1'b0 : di;
   assign bus8.Start   = sel8 ? start : 1'b0;
   assign bus8.Cmd     = sel8 ? cmd : 3'd0;
   assign bus8.Op_En   = sel8 ? opEn : 1'b0;
   assign bus8.Op_Inv  = sel8 ? opInv : 1'b0;
   assign bus8.PCU_DI  = sel8 ? di : 1'b0;

   logic        curBusy, curDone, curDo, curCy;
   logic [31:0] curIp, curW, curOp;

   assign curBusy = sel8 ? bus8.Busy   : bus16.Busy;
   assign curDone = sel8 ? bus8.Done   : bus16.Done;
   assign curDo   = sel8 ? bus8.PCU_DO : bus16.PCU_DO;
   assign curCy   = sel8 ? bus8.Cy     : bus16.Cy;
   assign curIp   = sel8 ? {24'd0, bus8.TstPort[23:16]} : {16'd0, bus16.TstPort[47:32]};
   assign curW    = sel8 ? {24'd0, bus8.TstPort[15:8]}  : {16'd0, bus16.TstPort[31:16]};
   assign curOp   = sel8 ? {24'd0, bus8.TstPort[7:0]}   : {16'd0, bus16.TstPort[15:0]};

   minicpu_serpcu_seq #(.pWidth(16)) dut16 (
      .Clk (clk),
      .Rst (rst16),
      .bus (bus16)
   );

   minicpu_serpcu_seq #(.pWidth(8)) dut8 (
      .Clk (clk),
      .Rst (rst8),
      .bus (bus8)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   // Hard stop in case a bounded wait is ever bypassed.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic exp_t mk(input logic [31:0] ip, input logic [31:0] w,
                               input logic [31:0] op, input logic cy, input int busy);
      exp_t e;
      e.ip = ip; e.w = w; e.op = op; e.cy = cy; e.busy = busy;
      return e;
   endfunction

   task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      assert (obs === exp) else begin
         errCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Pops the oldest expectation and compares it with the finished operation.
   task automatic checkOutput(input int busyN);
      exp_t e;
      if (sbQ.size() == 0) begin
         checkValue("sbEmpty", 32'd1, 32'd0);
      end else begin
         e = sbQ.pop_front();
         checkValue("busyCycles", busyN, e.busy);
         checkValue("ip", curIp, e.ip);
         checkValue("w", curW, e.w);
         checkValue("op", curOp, e.op);
         checkValue("cy", {31'd0, curCy}, {31'd0, e.cy});
      end
   endtask

   // Issues one word command, feeds load data, checks the serial output
   // stream bit by bit, then checks the Done pulse and the final registers.
   task automatic applyStimulus(input logic [2:0] c, input logic [31:0] ldData, input exp_t e);
      int          busyN;
      int          width;
      logic [31:0] tgt;
      width = sel8 ? 8 : 16;
      tgt   = (c == 3'd3 || c == 3'd5 || c == 3'd7) ? e.w : e.ip;
      sbQ.push_back(e);
      doQ.delete();
      for (int i = 0; i < width; i++) begin
         doQ.push_back((c == 3'd4 || c == 3'd5) ? 1'b0 : tgt[i]);
      end
      @(negedge clk);
      start = 1'b1;
      cmd   = c;
      @(negedge clk);
      start = 1'b0;
      cmd   = 3'd0;
      busyN = 0;
      for (int k = 0; k < 64; k++) begin
         if (!curBusy) break;
         di    = ldData[busyN % 32];
         opEn  = holdOpEn;
         start = pokeWhileBusy && (busyN == 3);
         cmd   = start ? 3'd4 : 3'd0;
         if (doQ.size() > 0) begin
            checkValue($sformatf("doBit%0d", busyN), {31'd0, curDo}, {31'd0, doQ.pop_front()});
         end
         busyN++;
         @(negedge clk);
      end
      opEn  = 1'b0;
      di    = 1'b0;
      start = 1'b0;
      cmd   = 3'd0;
      checkValue("busyDropped", {31'd0, curBusy}, 32'd0);
      checkValue("donePulse", {31'd0, curDone}, 32'd1);
      checkOutput(busyN);
      @(negedge clk);
      checkValue("doneOneCycle", {31'd0, curDone}, 32'd0);
   endtask

   // Shifts one nibble into Op MSB first; NFX complements on the last bit.
   task automatic shiftNibble(input logic [3:0] nib, input bit nfx);
      logic [3:0] n;
      n = nib;
      for (int b = 3; b >= 0; b--) begin
         @(negedge clk);
         opEn  = 1'b1;
         di    = n[b];
         opInv = nfx && (b == 0);
      end
      @(negedge clk);
      opEn  = 1'b0;
      opInv = 1'b0;
      di    = 1'b0;
   endtask

   initial begin
      int doneSeen;

      // Reset state, checked while reset is still asserted.
      #12;
      checkValue("rstTst", {16'd0, bus16.TstPort[47:32]} | bus16.TstPort[31:0], 32'd0);
      checkValue("rstBusy", {31'd0, bus16.Busy}, 32'd0);
      checkValue("rstDone", {31'd0, bus16.Done}, 32'd0);
      checkValue("rstDo", {31'd0, bus16.PCU_DO}, 32'd0);
      checkValue("rstCy", {31'd0, bus16.Cy}, 32'd0);
      @(negedge clk);
      rst16 = 1'b0;
      rst8  = 1'b0;

      // Two increments from reset; the second ignores a Start while busy.
      applyStimulus(3'd1, 32'd0, mk(32'h0001, 0, 0, 1'b0, 16));
      pokeWhileBusy = 1'b1;
      applyStimulus(3'd1, 32'd0, mk(32'h0002, 0, 0, 1'b0, 16));
      pokeWhileBusy = 1'b0;

      // Operand prefix sequence.
      shiftNibble(4'hF, 1'b1);
      checkValue("opNfxF", curOp, 32'hFFF0);
      shiftNibble(4'h5, 1'b0);
      checkValue("opPfx5", curOp, 32'hFF05);
      shiftNibble(4'h0, 1'b1);
      checkValue("opNfx0", curOp, 32'h0FAF);

      applyStimulus(3'd2, 32'd0, mk(32'h0FB1, 0, 0, 1'b0, 16));

      // Cmd=0 with Start must not start anything.
      @(negedge clk);
      start = 1'b1;
      cmd   = 3'd0;
      @(negedge clk);
      start = 1'b0;
      checkValue("nopBusy", {31'd0, curBusy}, 32'd0);
      @(negedge clk);
      checkValue("nopDone", {31'd0, curDone}, 32'd0);

      // Load all ones then increment to wrap with carry out.
      applyStimulus(3'd4, 32'h0000FFFF, mk(32'hFFFF, 0, 0, 1'b0, 16));
      applyStimulus(3'd1, 32'd0, mk(32'h0000, 0, 0, 1'b1, 16));

      // Load W serially, then stream it back out.
      applyStimulus(3'd5, 32'h00001234, mk(32'h0000, 32'h1234, 0, 1'b1, 16));
      applyStimulus(3'd7, 32'd0, mk(32'h0000, 32'h1234, 0, 1'b1, 16));

      // W += Op while Op_En is held: the Op shift must be suppressed.
      shiftNibble(4'h3, 1'b0);
      checkValue("opPfx3", curOp, 32'h0003);
      holdOpEn = 1'b1;
      applyStimulus(3'd3, 32'hFFFFFFFF, mk(32'h0000, 32'h1237, 0, 1'b0, 16));
      holdOpEn = 1'b0;

      // Abort an increment after bit 7 with an asynchronous reset.
      @(negedge clk);
      start = 1'b1;
      cmd   = 3'd1;
      @(negedge clk);
      start = 1'b0;
      cmd   = 3'd0;
      repeat (8) @(negedge clk);
      #2;
      rst16 = 1'b1;
      #1;
      checkValue("abortIp", curIp, 32'd0);
      checkValue("abortW", curW, 32'd0);
      checkValue("abortBusy", {31'd0, curBusy}, 32'd0);
      @(negedge clk);
      rst16 = 1'b0;
      doneSeen = 0;
      for (int k = 0; k < 20; k++) begin
         if (curDone) doneSeen++;
         @(negedge clk);
      end
      checkValue("abortNoDone", doneSeen, 0);
      applyStimulus(3'd1, 32'd0, mk(32'h0001, 0, 0, 1'b0, 16));

      // Narrow instance: wrap an 8-bit IP.
      sel8 = 1'b1;
      applyStimulus(3'd4, 32'h000000FF, mk(32'h00FF, 0, 0, 1'b0, 8));
      applyStimulus(3'd1, 32'd0, mk(32'h0000, 0, 0, 1'b1, 8));

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
